// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared widths, stage control bundles and forwarding encodings for ctrl_pipe
package ctrl_pkg;
    localparam int REG_W = 5;
    localparam int ALU_W = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic             valid;
        logic             reg_dst;
        logic             alu_src;
        logic [ALU_W-1:0] alu_control;
        logic             pc_src;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             mem_write;
        logic             mem_read;
        logic             reg_write;
        logic             mem_to_reg;
    } ex_ctrl_t;

    typedef struct packed {
        logic             valid;
        logic             mem_write;
        logic             mem_read;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] wreg;
    } mem_ctrl_t;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] wreg;
    } wb_ctrl_t;

    // Register 0 is hardwired, so it never produces a hit.
    function automatic logic src_hit(input logic [REG_W-1:0] wreg,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
        return (wreg != '0) && ((wreg == rs) || (uses_rt && (wreg == rt)));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input logic             mem_rw,
                                           input logic [REG_W-1:0] mem_wreg,
                                           input logic             wb_rw,
                                           input logic [REG_W-1:0] wb_wreg);
        if (mem_rw && (mem_wreg != '0) && (mem_wreg == src))
            return FWD_MEM;
        if (wb_rw && (wb_wreg != '0) && (wb_wreg == src))
            return FWD_WB;
        return FWD_REG;
    endfunction
endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - combinational stall and forwarding-select logic
// CTRL_PIPE_FORWARD_EN selects load-use stall with forwarding; otherwise stall until the writer reaches WB.
module hazard_unit
    import ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_reg_write,
    input  logic [REG_W-1:0] i_ex_wreg,
    input  logic [REG_W-1:0] i_ex_rs,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_mem_reg_write,
    input  logic [REG_W-1:0] i_mem_wreg,
    input  logic             i_wb_reg_write,
    input  logic [REG_W-1:0] i_wb_wreg,
    output logic             o_stall,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b
);
    logic w_unused;

`ifdef CTRL_PIPE_FORWARD_EN
    assign o_stall  = i_ex_valid & i_ex_mem_read
                    & src_hit(i_ex_wreg, i_id_rs, i_id_rt, i_id_uses_rt);
    assign o_fwd_a  = fwd_sel(i_ex_rs, i_mem_reg_write, i_mem_wreg, i_wb_reg_write, i_wb_wreg);
    assign o_fwd_b  = fwd_sel(i_ex_rt, i_mem_reg_write, i_mem_wreg, i_wb_reg_write, i_wb_wreg);
    assign w_unused = i_ex_reg_write;
`else
    // No bypass paths: hold ID until every in-flight writer of a used source has left MEM.
    assign o_stall  = (i_ex_valid & i_ex_reg_write
                       & src_hit(i_ex_wreg, i_id_rs, i_id_rt, i_id_uses_rt))
                    | (i_mem_reg_write
                       & src_hit(i_mem_wreg, i_id_rs, i_id_rt, i_id_uses_rt));
    assign o_fwd_a  = FWD_REG;
    assign o_fwd_b  = FWD_REG;
    assign w_unused = ^{i_ex_mem_read, i_ex_rs, i_ex_rt, i_wb_reg_write, i_wb_wreg};
`endif
endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - EX/MEM/WB control pipeline with branch/jump flush and hazard handling
// Forwarding is enabled by CTRL_PIPE_FORWARD_EN (see hazard_unit).
module ctrl_pipe
    import ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_RegDst,
    input  logic             id_RegWrite,
    input  logic             id_ALUSrc,
    input  logic             id_MemWrite,
    input  logic             id_MemRead,
    input  logic             id_MemToReg,
    input  logic             id_PCSrc,
    input  logic             id_JumpPC,
    input  logic [ALU_W-1:0] id_ALUControl,
    input  logic             ex_zero,
    output logic             ex_RegDst,
    output logic             ex_ALUSrc,
    output logic [ALU_W-1:0] ex_ALUControl,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic             mem_MemWrite,
    output logic             mem_MemRead,
    output logic             wb_RegWrite,
    output logic             wb_MemToReg,
    output logic [REG_W-1:0] wb_wreg,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             ifid_flush
);
    ex_ctrl_t         r_ex, w_ex_next;
    mem_ctrl_t        r_mem, w_mem_next;
    wb_ctrl_t         r_wb, w_wb_next;
    logic [REG_W-1:0] w_ex_wreg;
    logic             w_br_take;
    logic             w_hz_stall;

    assign w_ex_wreg = r_ex.reg_dst ? r_ex.rd : r_ex.rt;
    assign w_br_take = r_ex.valid & r_ex.pc_src & ex_zero;

    hazard_unit u_hazard (
        .i_id_rs         (id_rs),
        .i_id_rt         (id_rt),
        .i_id_uses_rt    (~id_ALUSrc | id_MemWrite),
        .i_ex_valid      (r_ex.valid),
        .i_ex_mem_read   (r_ex.mem_read),
        .i_ex_reg_write  (r_ex.reg_write),
        .i_ex_wreg       (w_ex_wreg),
        .i_ex_rs         (r_ex.rs),
        .i_ex_rt         (r_ex.rt),
        .i_mem_reg_write (r_mem.valid & r_mem.reg_write),
        .i_mem_wreg      (r_mem.wreg),
        .i_wb_reg_write  (r_wb.valid & r_wb.reg_write),
        .i_wb_wreg       (r_wb.wreg),
        .o_stall         (w_hz_stall),
        .o_fwd_a         (fwd_a),
        .o_fwd_b         (fwd_b)
    );

    // A taken branch squashes the stalled instruction; a stalled jump flushes on its retry.
    assign stall      = ~rst & w_hz_stall & ~w_br_take;
    assign ifid_flush = ~rst & (w_br_take | (id_valid & id_JumpPC & ~w_hz_stall));

    always_comb begin
        w_ex_next = '0;
        if (id_valid && !stall && !w_br_take) begin
            w_ex_next.valid       = 1'b1;
            w_ex_next.reg_dst     = id_RegDst;
            w_ex_next.alu_src     = id_ALUSrc;
            w_ex_next.alu_control = id_ALUControl;
            w_ex_next.pc_src      = id_PCSrc;
            w_ex_next.rs          = id_rs;
            w_ex_next.rt          = id_rt;
            w_ex_next.rd          = id_rd;
            w_ex_next.mem_write   = id_MemWrite;
            w_ex_next.mem_read    = id_MemRead;
            w_ex_next.reg_write   = id_RegWrite;
            w_ex_next.mem_to_reg  = id_MemToReg;
        end
    end

    always_comb begin
        w_mem_next            = '0;
        w_mem_next.valid      = r_ex.valid;
        w_mem_next.mem_write  = r_ex.mem_write;
        w_mem_next.mem_read   = r_ex.mem_read;
        w_mem_next.reg_write  = r_ex.reg_write;
        w_mem_next.mem_to_reg = r_ex.mem_to_reg;
        w_mem_next.wreg       = w_ex_wreg;
    end

    always_comb begin
        w_wb_next            = '0;
        w_wb_next.valid      = r_mem.valid;
        w_wb_next.reg_write  = r_mem.reg_write;
        w_wb_next.mem_to_reg = r_mem.mem_to_reg;
        w_wb_next.wreg       = r_mem.wreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= w_ex_next;
            r_mem <= w_mem_next;
            r_wb  <= w_wb_next;
        end
    end

    assign ex_RegDst     = r_ex.reg_dst;
    assign ex_ALUSrc     = r_ex.alu_src;
    assign ex_ALUControl = r_ex.alu_control;
    assign ex_rs         = r_ex.rs;
    assign ex_rt         = r_ex.rt;
    assign mem_MemWrite  = r_mem.mem_write;
    assign mem_MemRead   = r_mem.mem_read;
    assign wb_RegWrite   = r_wb.reg_write;
    assign wb_MemToReg   = r_wb.mem_to_reg;
    assign wb_wreg       = r_wb.wreg;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed table plus randomized run of ctrl_pipe against an in-flight instruction model
// Expectations follow CTRL_PIPE_FORWARD_EN when it is defined.
module tb_ctrl_pipe;
`ifdef CTRL_PIPE_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, ex_zero;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_RegDst, id_RegWrite, id_ALUSrc, id_MemWrite, id_MemRead, id_MemToReg, id_PCSrc, id_JumpPC;
    logic [3:0] id_ALUControl;
    logic       ex_RegDst, ex_ALUSrc, mem_MemWrite, mem_MemRead, wb_RegWrite, wb_MemToReg, stall, ifid_flush;
    logic [3:0] ex_ALUControl;
    logic [4:0] ex_rs, ex_rt, wb_wreg;
    logic [1:0] fwd_a, fwd_b;

    ctrl_pipe dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc),
        .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead), .id_MemToReg(id_MemToReg),
        .id_PCSrc(id_PCSrc), .id_JumpPC(id_JumpPC), .id_ALUControl(id_ALUControl),
        .ex_zero(ex_zero),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUControl(ex_ALUControl),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
        .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_wreg(wb_wreg),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .ifid_flush(ifid_flush)
    );

    typedef struct packed {
        logic       valid;
        logic [4:0] rs, rt, rd;
        logic       reg_dst, reg_write, alu_src, mem_write, mem_read, mem_to_reg, pc_src, jump;
        logic [3:0] alu;
    } instr_t;

    typedef struct {
        instr_t     id;
        logic       zero;
        logic       rst;
        logic       st;
        logic       fl;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    int     n_vec  = 0;
    int     n_miss = 0;
    instr_t pipe [3];
    logic   m_stall;
    vec_t   tbl[$];

    function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic dst, input logic rw, input logic asrc, input logic mw,
                                  input logic mr, input logic m2r, input logic pcs, input logic jmp,
                                  input logic [3:0] alu);
        instr_t i;
        i.valid = 1'b1; i.rs = rs; i.rt = rt; i.rd = rd;
        i.reg_dst = dst; i.reg_write = rw; i.alu_src = asrc; i.mem_write = mw;
        i.mem_read = mr; i.mem_to_reg = m2r; i.pc_src = pcs; i.jump = jmp; i.alu = alu;
        return i;
    endfunction

    function automatic instr_t i_lw(input logic [4:0] rt, input logic [4:0] rs);
        return mk(rs, rt, 5'd0, 0, 1, 1, 0, 1, 1, 0, 0, 4'h2);
    endfunction
    function automatic instr_t i_sw(input logic [4:0] rt, input logic [4:0] rs);
        return mk(rs, rt, 5'd0, 0, 0, 1, 1, 0, 0, 0, 0, 4'h2);
    endfunction
    function automatic instr_t i_alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] op);
        return mk(rs, rt, rd, 1, 1, 0, 0, 0, 0, 0, 0, op);
    endfunction
    function automatic instr_t i_beq(input logic [4:0] rs, input logic [4:0] rt);
        return mk(rs, rt, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h6);
    endfunction
    function automatic instr_t i_j(input logic [4:0] rs);
        return mk(rs, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 0, 1, 4'h0);
    endfunction

    function automatic logic [4:0] dest(input instr_t i);
        return i.reg_dst ? i.rd : i.rt;
    endfunction

    // Does producer p write a non-zero register that consumer c actually reads?
    function automatic bit feeds(input instr_t p, input instr_t c);
        logic [4:0] d;
        d = dest(p);
        return p.valid && p.reg_write && (d != 0) &&
               ((d == c.rs) || ((!c.alu_src || c.mem_write) && (d == c.rt)));
    endfunction

    function automatic bit hazard(input instr_t id);
        if (FWD_EN) return pipe[0].mem_read && feeds(pipe[0], id);
        return feeds(pipe[0], id) || feeds(pipe[1], id);
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] src);
        logic [1:0] r;
        r = 2'b00;
        if (src != 0 && pipe[2].valid && pipe[2].reg_write && dest(pipe[2]) == src) r = 2'b01;
        if (src != 0 && pipe[1].valid && pipe[1].reg_write && dest(pipe[1]) == src) r = 2'b10;
        return FWD_EN ? r : 2'b00;
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic step(input instr_t id, input logic zero, input logic r, input bit use_tbl,
                        input vec_t v, input string tag);
        logic br, hz, e_st, e_fl;
        logic [1:0] e_fa, e_fb;
        rst = r; ex_zero = zero;
        id_valid = id.valid; id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
        id_RegDst = id.reg_dst; id_RegWrite = id.reg_write; id_ALUSrc = id.alu_src;
        id_MemWrite = id.mem_write; id_MemRead = id.mem_read; id_MemToReg = id.mem_to_reg;
        id_PCSrc = id.pc_src; id_JumpPC = id.jump; id_ALUControl = id.alu;
        br   = pipe[0].valid && pipe[0].pc_src && zero;
        hz   = hazard(id);
        e_st = !r && hz && !br;
        e_fl = !r && (br || (id.valid && id.jump && !hz));
        e_fa = fwd(pipe[0].rs);
        e_fb = fwd(pipe[0].rt);
        @(negedge clk);
        chk(tag, "stall",         32'(stall),         32'(e_st));
        chk(tag, "ifid_flush",    32'(ifid_flush),    32'(e_fl));
        chk(tag, "fwd_a",         32'(fwd_a),         32'(e_fa));
        chk(tag, "fwd_b",         32'(fwd_b),         32'(e_fb));
        chk(tag, "ex_RegDst",     32'(ex_RegDst),     32'(pipe[0].reg_dst));
        chk(tag, "ex_ALUSrc",     32'(ex_ALUSrc),     32'(pipe[0].alu_src));
        chk(tag, "ex_ALUControl", 32'(ex_ALUControl), 32'(pipe[0].alu));
        chk(tag, "ex_rs",         32'(ex_rs),         32'(pipe[0].rs));
        chk(tag, "ex_rt",         32'(ex_rt),         32'(pipe[0].rt));
        chk(tag, "mem_MemWrite",  32'(mem_MemWrite),  32'(pipe[1].mem_write));
        chk(tag, "mem_MemRead",   32'(mem_MemRead),   32'(pipe[1].mem_read));
        chk(tag, "wb_RegWrite",   32'(wb_RegWrite),   32'(pipe[2].reg_write));
        chk(tag, "wb_MemToReg",   32'(wb_MemToReg),   32'(pipe[2].mem_to_reg));
        chk(tag, "wb_wreg",       32'(wb_wreg),       32'(dest(pipe[2])));
        if (use_tbl) begin
            chk(tag, "tbl_stall", 32'(stall),      32'(v.st));
            chk(tag, "tbl_flush", 32'(ifid_flush), 32'(v.fl));
            chk(tag, "tbl_fwd_a", 32'(fwd_a),      32'(v.fa));
            chk(tag, "tbl_fwd_b", 32'(fwd_b),      32'(v.fb));
        end
        @(posedge clk);
        if (r) begin
            pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (id.valid && !e_st && !br) ? id : '0;
        end
        m_stall = e_st;
        #1;
    endtask

    task automatic row(input instr_t id, input logic z, input logic r, input logic st,
                       input logic fl, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.id = id; v.zero = z; v.rst = r; v.st = st; v.fl = fl; v.fa = fa; v.fb = fb;
        tbl.push_back(v);
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        logic [4:0] a, b, c;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
            0:       i = i_lw(b, a);
            1:       i = i_alu(c, a, b, 4'h2);
            2:       i = i_alu(c, a, b, 4'h6);
            3:       i = i_sw(b, a);
            4:       i = i_beq(a, b);
            default: i = i_j(a);
        endcase
        if ($urandom_range(0, 3) == 0) i.valid = 1'b0;
        return i;
    endfunction

    initial begin
        vec_t   dummy;
        instr_t cur;
        dummy = '{id: '0, zero: 1'b0, rst: 1'b0, st: 1'b0, fl: 1'b0, fa: 2'b00, fb: 2'b00};
        rst = 1'b1; ex_zero = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_RegDst = 0; id_RegWrite = 0; id_ALUSrc = 0; id_MemWrite = 0; id_MemRead = 0;
        id_MemToReg = 0; id_PCSrc = 0; id_JumpPC = 0; id_ALUControl = '0;
        repeat (2) @(posedge clk);
        #1;
        pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        m_stall = 1'b0;

        row(i_lw(2, 1),           0, 0, 0, 0, 2'b00, 2'b00);
        row(i_alu(3, 2, 4, 2),    0, 0, 1, 0, 2'b00, 2'b00);
`ifdef CTRL_PIPE_FORWARD_EN
        row(i_alu(3, 2, 4, 2),    0, 0, 0, 0, 2'b00, 2'b00);
        row(i_alu(5, 1, 1, 2),    0, 0, 0, 0, 2'b01, 2'b00);
        row(i_alu(6, 5, 5, 6),    0, 0, 0, 0, 2'b00, 2'b00);
        row(i_beq(7, 7),          0, 0, 0, 0, 2'b10, 2'b10);
        row(i_alu(8, 1, 1, 2),    1, 0, 0, 1, 2'b00, 2'b00);
        row(i_j(0),               0, 0, 0, 1, 2'b00, 2'b00);
        row(i_lw(0, 1),           0, 0, 0, 0, 2'b00, 2'b00);
        row(i_alu(9, 0, 0, 2),    0, 0, 0, 0, 2'b00, 2'b00);
        row(i_lw(10, 1),          0, 0, 0, 0, 2'b00, 2'b00);
        row(i_j(10),              0, 0, 1, 0, 2'b00, 2'b00);
        row(i_j(10),              0, 0, 0, 1, 2'b00, 2'b00);
        row(i_alu(11, 1, 1, 2),   0, 0, 0, 0, 2'b01, 2'b00);
`else
        row(i_alu(3, 2, 4, 2),    0, 0, 1, 0, 2'b00, 2'b00);
        row(i_alu(3, 2, 4, 2),    0, 0, 0, 0, 2'b00, 2'b00);
        row(i_alu(5, 1, 1, 2),    0, 0, 0, 0, 2'b00, 2'b00);
        row(i_alu(6, 5, 5, 6),    0, 0, 1, 0, 2'b00, 2'b00);
        row(i_alu(6, 5, 5, 6),    0, 0, 1, 0, 2'b00, 2'b00);
        row(i_alu(6, 5, 5, 6),    0, 0, 0, 0, 2'b00, 2'b00);
        row(i_beq(7, 7),          0, 0, 0, 0, 2'b00, 2'b00);
        row(i_alu(8, 1, 1, 2),    1, 0, 0, 1, 2'b00, 2'b00);
        row(i_j(0),               0, 0, 0, 1, 2'b00, 2'b00);
        row(i_lw(0, 1),           0, 0, 0, 0, 2'b00, 2'b00);
        row(i_alu(9, 0, 0, 2),    0, 0, 0, 0, 2'b00, 2'b00);
        row(i_lw(10, 1),          0, 0, 0, 0, 2'b00, 2'b00);
        row(i_j(10),              0, 0, 1, 0, 2'b00, 2'b00);
        row(i_j(10),              0, 0, 1, 0, 2'b00, 2'b00);
        row(i_j(10),              0, 0, 0, 1, 2'b00, 2'b00);
        row(i_alu(11, 1, 1, 2),   0, 0, 0, 0, 2'b00, 2'b00);
`endif
        row(i_alu(12, 1, 1, 2),   0, 0, 0, 0, 2'b00, 2'b00);
        row(i_alu(13, 1, 1, 2),   0, 0, 0, 0, 2'b00, 2'b00);
        row(i_alu(14, 1, 1, 2),   0, 1, 0, 0, 2'b00, 2'b00);
        row('0,                   0, 0, 0, 0, 2'b00, 2'b00);

        for (int k = 0; k < tbl.size(); k++)
            step(tbl[k].id, tbl[k].zero, tbl[k].rst, 1'b1, tbl[k], $sformatf("tbl%0d", k));

        cur = '0;
        for (int k = 0; k < 400; k++) begin
            if (!m_stall) cur = rand_instr();
            step(cur, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), 1'b0, dummy,
                 $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the control bundle produced by the instruction decoder from ID through EX, MEM and WB, and delivers each stage's control bits to the datapath. Also detects data and load-use hazards, generates stall and flush, and drives the forwarding-mux selects. It sits between the decode controller and the pipelined datapath registers.

## Interface
- No parameters. Register-index width is fixed at 5 and ALU control width at 4, both defined in the package.
- `clk` in 1: the only clock. Rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_rs`, `id_rt`, `id_rd` in 5 each: source and destination register fields.
- `id_RegDst`, `id_RegWrite`, `id_ALUSrc`, `id_MemWrite`, `id_MemRead`, `id_MemToReg`, `id_PCSrc`, `id_JumpPC` in 1 each: decoded controls.
- `id_ALUControl` in 4: decoded ALU operation.
- `ex_zero` in 1: ALU zero flag for the instruction in EX.
- `ex_RegDst`, `ex_ALUSrc` out 1 each, and `ex_ALUControl` out 4: EX-stage controls.
- `ex_rs`, `ex_rt` out 5 each: EX-stage source indices.
- `mem_MemWrite`, `mem_MemRead` out 1 each: MEM-stage controls.
- `wb_RegWrite`, `wb_MemToReg` out 1 each, and `wb_wreg` out 5: WB-stage controls and destination.
- `fwd_a`, `fwd_b` out 2 each: forwarding selects for ALU operands A and B.
- `stall` out 1: hold PC and IF/ID. Combinational.
- `ifid_flush` out 1: clear IF/ID. Combinational.

## Operation
- There are three stage registers: EX, MEM and WB. Each holds a valid bit plus the control fields still needed downstream.
- A bubble is defined as all fields zero.
- Every rising edge, each stage advances: EX to MEM, and MEM to WB.
- ID loads into EX unless the EX input is a bubble. The EX input is a bubble when `stall` is high, when a branch flush is active, or when `id_valid` is 0.
- EX destination: `ex_wreg = ex_RegDst ? ex_rd : ex_rt`. This value is registered into MEM as `mem_wreg`.
- Branch taken: `br_take = ex_valid & ex_PCSrc & ex_zero`.
- When `br_take` is high, `ifid_flush` = 1 and the ID instruction becomes a bubble in EX.
- Jump: `id_valid & id_JumpPC` drives `ifid_flush` = 1. The jump itself proceeds into EX normally.
- ID uses rt when `!id_ALUSrc | id_MemWrite`. Register 0 never causes a hazard and is never forwarded.
- Load-use stall: asserted when `ex_valid & ex_MemRead`, `ex_wreg != 0`, and `ex_wreg` equals `id_rs`, or equals `id_rt` when ID uses rt.
- Forward A, in priority order:
  - `fwd_a` = 2'b10 when MEM RegWrite is set, `mem_wreg != 0`, and `mem_wreg == ex_rs`.
  - Otherwise `fwd_a` = 2'b01 when WB RegWrite is set, `wb_wreg != 0`, and `wb_wreg == ex_rs`.
  - Otherwise `fwd_a` = 2'b00.
- `fwd_b` uses the same rules against `ex_rt`.
- Simultaneous stall and `br_take`: the flush wins and `stall` is forced to 0, because the stalled instruction is squashed.
- Jump flush and stall together: `stall` = 1 and `ifid_flush` = 0. The jump re-presents next cycle and flushes then.

## Timing
- Control latency: ID to EX is 1 cycle, EX to MEM is 1 cycle, MEM to WB is 1 cycle.
- `stall`, `ifid_flush`, `fwd_a` and `fwd_b` are combinational from the current stage registers and ID inputs. They are valid in the same cycle.
- A load-use stall lasts exactly 1 cycle when forwarding is enabled.
- Reset: all stage registers are cleared to bubble. All outputs are 0: `ex_*`, `mem_*`, `wb_*`, `fwd_a`/`fwd_b` = 0; `stall` = 0; `ifid_flush` = 0.
- Reset mid-operation discards every in-flight instruction on the reset edge.
- The register file is write-first, so no WB-to-ID hazard exists.

## Configuration
- Macro: `CTRL_PIPE_FORWARD_EN`.
- Defined: forwarding and load-use stall behave as described above.
- Undefined:
  - `fwd_a` and `fwd_b` are tied to 2'b00.
  - `stall` is asserted for any used ID source (non-zero) that matches a valid RegWrite destination in EX (`ex_wreg`) or MEM (`mem_wreg`).
  - The stall repeats each cycle until the writer reaches WB, so it lasts up to 2 cycles.

## Structure
- Package `ctrl_pkg` holds:
  - the stage control bundle typedefs: `ex_ctrl_t`, `mem_ctrl_t`, `wb_ctrl_t`;
  - the register index width;
  - the forwarding encodings `FWD_REG = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`.
- Sub-module `hazard_unit` holds the stall and forwarding logic, which is purely combinational. The stage registers and flush logic stay in `ctrl_pipe`.

## Test plan
- `lw $2` then `add $3,$2,$4` back-to-back: `stall` = 1 for one cycle, EX gets a bubble, then `fwd_a` = 2'b01 when the add is in EX.
- `add $5,..` then `sub $6,$5,$5`: no stall, and `fwd_a` = `fwd_b` = 2'b10 in the sub's EX cycle.
- `beq` with `ex_zero` = 1: `ifid_flush` = 1, and the next EX is a bubble (`ex_ALUControl` = 0, no MEM write).
- `id_JumpPC` = 1: `ifid_flush` = 1 that cycle, and the jump enters EX on the next edge.
- Destination `$0` on a load followed by a use of `$0`: no stall, and forward selects stay 2'b00.
- `rst` asserted with three valid instructions in flight: all outputs are 0 on the next edge. Build with `CTRL_PIPE_FORWARD_EN` undefined: the add-after-add case stalls for 2 cycles.
